// File: rtl/violation_logger_fifo_if.sv
// Read port of the violation logger: show-ahead head record with valid/ready handshake.
interface violation_logger_fifo_if #(
    parameter int REC_W = 56
) ();
    logic             rd_valid;
    logic             rd_ready;
    logic [REC_W-1:0] rd_data;

    modport master (output rd_valid, output rd_data, input rd_ready);
    modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/violation_logger_fifo.sv
// Edge-detects violation requests and logs one timestamped PC/bus snapshot per event into a FIFO.
// Latency: record visible on rd port one cycle after the rising request is sampled.
// Backpressure: rd_ready low holds the head record; events arriving while full are dropped and counted.
module violation_logger_fifo #(
    parameter int               N_SRC    = 6,
    parameter int               ADDR_W   = 16,
    parameter int               TS_W     = 16,
    parameter int               DEPTH    = 16,
    parameter logic [N_SRC-1:0] DMA_MASK = 6'b111000,
    localparam int              REC_W    = N_SRC + TS_W + 2*ADDR_W + 2,
    localparam int              LVL_W    = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [N_SRC-1:0]      src_viol,
    input  logic                  log_en,
    input  logic                  clr,
    input  logic [ADDR_W-1:0]     pc,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic                  data_en,
    input  logic                  data_wr,
    input  logic [ADDR_W-1:0]     dma_addr,
    input  logic                  dma_en,
    violation_logger_fifo_if.master rd,
    output logic [LVL_W-1:0]      level,
    output logic                  overflow,
    output logic [15:0]           drop_cnt
);
    localparam int              AW       = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [N_SRC-1:0]  src_prev;
    logic [N_SRC-1:0]  rise;
    logic [N_SRC-1:0]  rise_low;
    logic [TS_W-1:0]   ts;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [REC_W-1:0]  mem [DEPTH];
    logic [REC_W-1:0]  rec;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_en;
    logic              sel_wr;
    logic              dma_sel;
    logic              evt;
    logic              full;
    logic              not_empty;
    logic              push;
    logic              pop;
    logic              drop;

    assign rise      = src_viol & ~src_prev;
    // Isolate the lowest risen bit: it decides which bus the record snapshots.
    assign rise_low  = rise & (~rise + N_SRC'(1));
    assign dma_sel   = |(rise_low & DMA_MASK);

    assign sel_addr  = dma_sel ? dma_addr : data_addr;
    assign sel_en    = dma_sel ? dma_en   : data_en;
    assign sel_wr    = dma_sel ? 1'b0     : data_wr;
    assign rec       = {rise, ts, pc, sel_addr, sel_en, sel_wr};

    assign evt       = log_en & (|rise) & ~clr;
    assign full      = (level == FULL_LVL);
    assign not_empty = (level != '0);
    assign pop       = not_empty & rd.rd_ready & ~clr;
    assign push      = evt & (~full | pop);
    assign drop      = evt & full & ~pop;

    assign rd.rd_valid = not_empty;
    assign rd.rd_data  = not_empty ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rec;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_prev <= '0;
            ts       <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            // Edge history and timestamp keep running through clr and log_en=0.
            src_prev <= src_viol;
            ts       <= ts + TS_W'(1);
            if (clr) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                level    <= '0;
                overflow <= 1'b0;
                drop_cnt <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (push && !pop) begin
                    level <= level + LVL_W'(1);
                end else if (pop && !push) begin
                    level <= level - LVL_W'(1);
                end
                if (drop) begin
                    overflow <= 1'b1;
                    if (drop_cnt != 16'hFFFF) begin
                        drop_cnt <= drop_cnt + 16'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_violation_logger_fifo.sv
// Randomized + directed bench with a queue-based reference model and a decoupled negedge monitor.
module tb_violation_logger_fifo;
    localparam int N_SRC = 6;
    localparam int ADDR_W = 16;
    localparam int TS_W = 16;
    localparam int DEPTH = 16;
    localparam logic [N_SRC-1:0] DMA_MASK = 6'b111000;
    localparam int REC_W = N_SRC + TS_W + 2*ADDR_W + 2;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N_SRC-1:0]  src_viol;
    logic              log_en;
    logic              clr;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] data_addr;
    logic              data_en;
    logic              data_wr;
    logic [ADDR_W-1:0] dma_addr;
    logic              dma_en;
    logic [LVL_W-1:0]  level;
    logic              overflow;
    logic [15:0]       drop_cnt;

    violation_logger_fifo_if #(.REC_W(REC_W)) rd_if ();

    violation_logger_fifo #(
        .N_SRC(N_SRC), .ADDR_W(ADDR_W), .TS_W(TS_W), .DEPTH(DEPTH), .DMA_MASK(DMA_MASK)
    ) dut (
        .clk(clk), .reset_n(reset_n), .src_viol(src_viol), .log_en(log_en), .clr(clr),
        .pc(pc), .data_addr(data_addr), .data_en(data_en), .data_wr(data_wr),
        .dma_addr(dma_addr), .dma_en(dma_en), .rd(rd_if.master),
        .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    logic [REC_W-1:0] exp_q[$];
    int               mdl_level;
    bit               mdl_ovf;
    int               mdl_drop;
    logic [N_SRC-1:0] mdl_prev;
    logic [TS_W-1:0]  mdl_ts;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: what the logger should contain after each clock edge.
    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                exp_q.delete();
                mdl_level = 0;
                mdl_ovf = 0;
                mdl_drop = 0;
                mdl_prev = '0;
                mdl_ts = '0;
            end else begin
                logic [N_SRC-1:0] r;
                bit ev, pp;
                int p;
                logic [REC_W-1:0] rec;
                r = src_viol & ~mdl_prev;
                mdl_prev = src_viol;
                ev = log_en && (r != 0) && !clr;
                pp = (mdl_level != 0) && rd_if.rd_ready && !clr;
                if (clr) begin
                    exp_q.delete();
                    mdl_level = 0;
                    mdl_ovf = 0;
                    mdl_drop = 0;
                end else begin
                    if (pp) mdl_level--;
                    if (ev) begin
                        p = 0;
                        while (!r[p]) p++;
                        if (DMA_MASK[p]) rec = {r, mdl_ts, pc, dma_addr, dma_en, 1'b0};
                        else             rec = {r, mdl_ts, pc, data_addr, data_en, data_wr};
                        if (mdl_level < DEPTH) begin
                            exp_q.push_back(rec);
                            mdl_level++;
                        end else begin
                            mdl_ovf = 1;
                            if (mdl_drop < 65535) mdl_drop++;
                        end
                    end
                end
                mdl_ts = mdl_ts + 1'b1;
            end
        end
    end

    // Monitor: compares the presented outputs and retires records on accepted handshakes.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                check("rd_valid", 64'(rd_if.rd_valid), 64'(exp_q.size() != 0));
                check("level", 64'(level), 64'(mdl_level));
                check("overflow", 64'(overflow), 64'(mdl_ovf));
                check("drop_cnt", 64'(drop_cnt), 64'(mdl_drop));
                if (exp_q.size() != 0) begin
                    check("rd_data", 64'(rd_if.rd_data), 64'(exp_q[0]));
                    if (rd_if.rd_ready && !clr) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic pulse_events(input int n);
        for (int i = 0; i < n; i++) begin
            src_viol = 6'b000001;
            pc = 16'($urandom);
            data_addr = 16'($urandom);
            tick();
            src_viol = '0;
            tick();
        end
    endtask

    task automatic drain();
        rd_if.rd_ready = 1'b1;
        repeat (DEPTH + 2) tick();
        rd_if.rd_ready = 1'b0;
    endtask

    initial begin
        logic [REC_W-1:0] want;
        reset_n = 1'b0;
        src_viol = '0;
        log_en = 1'b0;
        clr = 1'b0;
        pc = '0;
        data_addr = '0;
        data_en = 1'b0;
        data_wr = 1'b0;
        dma_addr = '0;
        dma_en = 1'b0;
        rd_if.rd_ready = 1'b0;
        #2;
        check("reset rd_valid", 64'(rd_if.rd_valid), 64'd0);
        check("reset rd_data", 64'(rd_if.rd_data), 64'd0);
        check("reset level", 64'(level), 64'd0);
        check("reset drop_cnt", 64'(drop_cnt), 64'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        log_en = 1'b1;

        // Single CPU event captured at ts=5.
        repeat (5) tick();
        src_viol = 6'b000010;
        pc = 16'hE010;
        data_addr = 16'h0200;
        data_en = 1'b1;
        data_wr = 1'b1;
        tick();
        want = {6'b000010, 16'd5, 16'hE010, 16'h0200, 1'b1, 1'b1};
        check("single rd_valid", 64'(rd_if.rd_valid), 64'd1);
        check("single record", 64'(rd_if.rd_data), 64'(want));
        repeat (10) tick();
        check("held level", 64'(level), 64'd1);
        src_viol = '0;
        drain();

        // Coincident DMA sources.
        src_viol = 6'b011000;
        dma_addr = 16'hA000;
        dma_en = 1'b1;
        data_addr = 16'h1234;
        data_wr = 1'b1;
        tick();
        check("dma mask", 64'(rd_if.rd_data[REC_W-1 -: N_SRC]), 64'(6'b011000));
        check("dma addr", 64'(rd_if.rd_data[17:2]), 64'h0000_0000_0000_A000);
        check("dma en/wr", 64'(rd_if.rd_data[1:0]), 64'd2);
        check("dma level", 64'(level), 64'd1);
        src_viol = '0;
        drain();

        // Fill to overflow, then push+pop while full.
        pulse_events(18);
        check("fill level", 64'(level), 64'd16);
        check("fill overflow", 64'(overflow), 64'd1);
        check("fill drop_cnt", 64'(drop_cnt), 64'd2);
        src_viol = 6'b000001;
        rd_if.rd_ready = 1'b1;
        tick();
        check("full push+pop level", 64'(level), 64'd16);
        check("full push+pop drop", 64'(drop_cnt), 64'd2);
        src_viol = '0;
        repeat (15) tick();
        check("drain one left", 64'(rd_if.rd_valid), 64'd1);
        tick();
        check("drain empty", 64'(rd_if.rd_valid), 64'd0);
        rd_if.rd_ready = 1'b0;

        // clr with coincident event, then log_en gating.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        pulse_events(5);
        check("pre-clr level", 64'(level), 64'd5);
        src_viol = 6'b000001;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr level", 64'(level), 64'd0);
        check("clr drop_cnt", 64'(drop_cnt), 64'd0);
        src_viol = '0;
        tick();
        log_en = 1'b0;
        src_viol = 6'b000100;
        repeat (2) tick();
        log_en = 1'b1;
        repeat (3) tick();
        check("log_en gated level", 64'(level), 64'd0);
        src_viol = '0;
        tick();

        // Asynchronous reset with level=7 and overflow set.
        pulse_events(17);
        rd_if.rd_ready = 1'b1;
        repeat (9) tick();
        rd_if.rd_ready = 1'b0;
        check("pre-reset level", 64'(level), 64'd7);
        check("pre-reset overflow", 64'(overflow), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async rd_valid", 64'(rd_if.rd_valid), 64'd0);
        check("async level", 64'(level), 64'd0);
        check("async overflow", 64'(overflow), 64'd0);
        check("async drop_cnt", 64'(drop_cnt), 64'd0);
        check("async rd_data", 64'(rd_if.rd_data), 64'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        src_viol = 6'b000100;
        tick();
        check("ts restart", 64'(rd_if.rd_data[49:34]), 64'd3);
        src_viol = '0;
        drain();

        // Randomized traffic, light then heavy draining.
        for (int i = 0; i < 1200; i++) begin
            src_viol = ($urandom_range(0, 2) == 0) ? 6'($urandom) : src_viol;
            log_en = ($urandom_range(0, 7) != 0);
            clr = ($urandom_range(0, 59) == 0);
            rd_if.rd_ready = (i < 600) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            pc = 16'($urandom);
            data_addr = 16'($urandom);
            data_en = 1'($urandom);
            data_wr = 1'($urandom);
            dma_addr = 16'($urandom);
            dma_en = 1'($urandom);
            tick();
        end
        src_viol = '0;
        clr = 1'b0;
        drain();
        check("final empty", 64'(rd_if.rd_valid), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
